// File: rtl/ps_arb_pkg.sv
// Shared types and helpers for the priority-select round-robin arbiter.
package ps_arb_pkg;

    localparam int PS_N     = 8;
    localparam int PS_IDX_W = $clog2(PS_N);

    typedef logic [PS_N-1:0]     ps_req_t;
    typedef logic [PS_IDX_W-1:0] ps_idx_t;

    function automatic ps_idx_t onehot2bin(input ps_req_t oh);
        ps_idx_t idx;
        idx = '0;
        for (int i = 0; i < PS_N; i++) begin
            if (oh[i]) begin
                idx = idx | ps_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ps_rr_arb_prio_tree.sv
// Fixed lowest-index-first selector built from a tree of 2:1 direction cells.
module ps_prio_tree
    import ps_arb_pkg::*;
#(
    parameter int N = PS_N
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         req_up_o
);

    localparam int  LV  = $clog2(N);
    localparam logic EN  = 1'b1;
    localparam logic SEL = 1'b1;

    // Level 0 is the root, level LV holds the leaves.
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        logic [(1<<l)-1:0] up;
        logic [(1<<l)-1:0] dn;

        if (l == LV) begin : g_leaf
            assign up = req_i;
        end else begin : g_node
            for (genvar j = 0; j < (1<<l); j++) begin : g_cell
                assign up[j] = g_lvl[l+1].up[2*j] | g_lvl[l+1].up[2*j+1];
            end
        end

        if (l == 0) begin : g_root
            assign dn = EN;
        end else begin : g_kid
            for (genvar j = 0; j < (1<<l); j++) begin : g_cell
                if (j % 2 == 0) begin : g_lo
                    assign dn[j] = g_lvl[l-1].dn[j/2] & up[j]
                                 & (SEL | ~up[j+1]);
                end else begin : g_hi
                    assign dn[j] = g_lvl[l-1].dn[j/2] & up[j]
                                 & (~SEL | ~up[j-1]);
                end
            end
        end
    end

    assign gnt_o    = g_lvl[LV].dn;
    assign req_up_o = g_lvl[0].up[0];

endmodule

// File: rtl/ps_rr_arb.sv
// Registered round-robin arbiter with valid/ready grant output.
module ps_rr_arb
    import ps_arb_pkg::*;
#(
    parameter int N     = PS_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    input  logic             gnt_ready_i,
    output logic             gnt_valid_o,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             req_up_o,
    output logic [IDX_W-1:0] ptr_o
);

    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;

    logic [IDX_W-1:0] sel_ptr;
    logic [N-1:0]     hi_mask, req_hi;
    logic [N-1:0]     win_hi, win_lo, win;
    logic             hi_any, up_lo;
    logic             fire, load;
    ps_idx_t          win_bin;

    // A new load only happens with an empty register or alongside the fire
    // of the held grant, so rotate past the held grant to keep 1 grant/cycle fair.
    assign sel_ptr = valid_q ? idx_q : ptr_q;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i > int'(sel_ptr));
        end
    end

    assign req_hi = req_i & hi_mask;

    ps_prio_tree #(.N(N)) u_hi (
        .req_i   (req_hi),
        .gnt_o   (win_hi),
        .req_up_o(hi_any)
    );

    ps_prio_tree #(.N(N)) u_lo (
        .req_i   (req_i),
        .gnt_o   (win_lo),
        .req_up_o(up_lo)
    );

    assign win     = hi_any ? win_hi : win_lo;
    assign win_bin = onehot2bin(ps_req_t'(win));

    assign fire = valid_q & gnt_ready_i;
    assign load = en_i & up_lo & (~valid_q | gnt_ready_i);

    always_comb begin
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            gnt_d   = win;
            idx_d   = IDX_W'(win_bin);
            valid_d = 1'b1;
        end else if (fire) begin
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end
        if (fire) begin
            ptr_d = idx_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= IDX_W'(N-1);
        end else begin
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_valid_o = valid_q;
    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign ptr_o       = ptr_q;
    assign req_up_o    = up_lo;

endmodule

// File: tb/tb_ps_rr_arb.sv
// Directed N=4 checks plus a randomised N=8 invariant/fairness run.
module tb_ps_rr_arb;

    logic       clk;
    logic       rst_n;

    logic       e4, y4;
    logic [3:0] r4;
    logic       v4, up4;
    logic [3:0] g4;
    logic [1:0] i4, p4;

    logic       e8, y8;
    logic [7:0] r8;
    logic       v8, up8;
    logic [7:0] g8;
    logic [2:0] i8, p8;

    int tests = 0;
    int fails = 0;

    ps_rr_arb #(.N(4)) d4 (
        .clock_i    (clk),
        .reset_ni   (rst_n),
        .en_i       (e4),
        .req_i      (r4),
        .gnt_ready_i(y4),
        .gnt_valid_o(v4),
        .gnt_o      (g4),
        .gnt_idx_o  (i4),
        .req_up_o   (up4),
        .ptr_o      (p4)
    );

    ps_rr_arb #(.N(8)) d8 (
        .clock_i    (clk),
        .reset_ni   (rst_n),
        .en_i       (e8),
        .req_i      (r8),
        .gnt_ready_i(y8),
        .gnt_valid_o(v8),
        .gnt_o      (g8),
        .gnt_idx_o  (i8),
        .req_up_o   (up8),
        .ptr_o      (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic v, input logic [3:0] g,
                      input logic [1:0] idx, input logic [1:0] p);
        chk({tag, ".valid"}, 32'(v4), 32'(v));
        chk({tag, ".gnt"},   32'(g4), 32'(g));
        chk({tag, ".idx"},   32'(i4), 32'(idx));
        chk({tag, ".ptr"},   32'(p4), 32'(p));
    endtask

    task automatic set4(input logic [3:0] r, input logic e, input logic y);
        r4 = r;
        e4 = e;
        y4 = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       fire;
        logic [2:0] fidx;
        logic [7:0] rp;
        logic [2:0] bin;
        int         wt[8];
        int         maxw;

        rst_n = 1'b0;
        set4(4'b0000, 1'b0, 1'b0);
        r8 = '0;
        e8 = 1'b0;
        y8 = 1'b0;
        for (int i = 0; i < 8; i++) wt[i] = 0;

        #12;
        st("reset", 1'b0, 4'b0000, 2'd0, 2'd3);
        chk("reset.ptr8", 32'(p8), 32'd7);
        chk("req_up.zero", 32'(up4), 32'd0);
        rst_n = 1'b1;

        // Full request set rotates 0,1,2,3,0
        set4(4'b1111, 1'b1, 1'b1);
        #1;
        chk("req_up.one", 32'(up4), 32'd1);
        tick(); st("rr0", 1'b1, 4'b0001, 2'd0, 2'd3);
        tick(); st("rr1", 1'b1, 4'b0010, 2'd1, 2'd0);
        tick(); st("rr2", 1'b1, 4'b0100, 2'd2, 2'd1);
        tick(); st("rr3", 1'b1, 4'b1000, 2'd3, 2'd2);
        tick(); st("rr4", 1'b1, 4'b0001, 2'd0, 2'd3);
        set4(4'b0000, 1'b0, 1'b1);
        tick(); st("rr_drain", 1'b0, 4'b0000, 2'd0, 2'd0);

        // Back-pressure
        set4(4'b0110, 1'b1, 1'b0);
        tick(); st("bp0", 1'b1, 4'b0010, 2'd1, 2'd0);
        tick(); st("bp1", 1'b1, 4'b0010, 2'd1, 2'd0);
        tick(); st("bp2", 1'b1, 4'b0010, 2'd1, 2'd0);
        y4 = 1'b1;
        tick(); st("bp_fire", 1'b1, 4'b0100, 2'd2, 2'd1);
        set4(4'b0000, 1'b0, 1'b1);
        tick(); st("bp_drain", 1'b0, 4'b0000, 2'd0, 2'd2);

        // Wrap-around from ptr=3
        set4(4'b1000, 1'b1, 1'b1);
        tick(); st("wr_pre", 1'b1, 4'b1000, 2'd3, 2'd2);
        set4(4'b0000, 1'b0, 1'b1);
        tick(); st("wr_ptr3", 1'b0, 4'b0000, 2'd0, 2'd3);
        set4(4'b1001, 1'b1, 1'b0);
        tick(); st("wr0", 1'b1, 4'b0001, 2'd0, 2'd3);
        y4 = 1'b1;
        tick(); st("wr3", 1'b1, 4'b1000, 2'd3, 2'd0);
        set4(4'b0000, 1'b0, 1'b1);
        tick(); st("wr_drain", 1'b0, 4'b0000, 2'd0, 2'd3);

        // Committed grant survives req drop and en=0
        set4(4'b0100, 1'b1, 1'b0);
        tick(); st("cm0", 1'b1, 4'b0100, 2'd2, 2'd3);
        set4(4'b0000, 1'b0, 1'b0);
        tick(); st("cm1", 1'b1, 4'b0100, 2'd2, 2'd3);
        tick(); st("cm2", 1'b1, 4'b0100, 2'd2, 2'd3);
        y4 = 1'b1;
        tick(); st("cm_fire", 1'b0, 4'b0000, 2'd0, 2'd2);

        // Async reset while holding a grant
        set4(4'b1111, 1'b1, 1'b0);
        tick(); st("ar0", 1'b1, 4'b1000, 2'd3, 2'd2);
        set4(4'b0000, 1'b1, 1'b0);
        tick(); st("ar_noreq", 1'b1, 4'b1000, 2'd3, 2'd2);
        #2 rst_n = 1'b0;
        #1 st("ar_rst", 1'b0, 4'b0000, 2'd0, 2'd3);
        #2 rst_n = 1'b1;
        set4(4'b1000, 1'b1, 1'b1);
        tick(); st("ar_post", 1'b1, 4'b1000, 2'd3, 2'd3);
        set4(4'b0000, 1'b0, 1'b1);
        tick(); st("ar_drain", 1'b0, 4'b0000, 2'd0, 2'd3);

        // Random N=8: invariants and bounded waiting
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) r8[b] = ~r8[b];
            end
            e8 = ($urandom_range(9) != 0);
            y8 = ($urandom_range(3) != 0);
            #1;
            chk("rnd.req_up", 32'(up8), 32'(|r8));
            fire = v8 & y8;
            fidx = i8;
            rp   = r8;
            tick();
            maxw = 0;
            for (int i = 0; i < 8; i++) begin
                if (!rp[i] || (fire && fidx == 3'(i))) wt[i] = 0;
                else if (fire) wt[i]++;
                if (wt[i] > maxw) maxw = wt[i];
            end
            chk("rnd.fair", 32'(maxw <= 8), 32'd1);
            chk("rnd.onehot", 32'((g8 & (g8 - 8'd1)) == 8'd0), 32'd1);
            chk("rnd.valid", 32'(g8 != 8'd0), 32'(v8));
            bin = '0;
            for (int i = 0; i < 8; i++) begin
                if (g8[i]) bin = bin | 3'(i);
            end
            chk("rnd.idx", 32'(i8), 32'(bin));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
